// File: rtl/exc_commit_ctrl_if.sv
// ============================================================================
// Module  : exc_commit_ctrl_if
// Purpose : WB / CSR / Pre-IF signal bundle for the exception commit sequencer.
//           BADV write port present only when EXC_BADV_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface exc_commit_ctrl_if;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_pc;
   logic [4:0]  wb_exc;
   logic        wb_ertn;
   logic [31:0] wb_vaddr;
   logic        has_int;
   logic [31:0] ex_entry;
   logic [31:0] csr_era;
   logic        csr_wb_ex;
   logic [5:0]  csr_wb_ecode;
   logic [8:0]  csr_wb_esubcode;
   logic [31:0] csr_wb_pc;
   logic        csr_ertn_flush;
   logic        flush_pipe;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
`ifdef EXC_BADV_EN
   logic        badv_we;
   logic [31:0] badv_wdata;
`endif

   // master: WB stage, CSR unit and Pre-IF side
   modport master (
      output wb_valid, wb_pc, wb_exc, wb_ertn, wb_vaddr,
      output has_int, ex_entry, csr_era, redirect_ready,
      input  wb_ready, csr_wb_ex, csr_wb_ecode, csr_wb_esubcode, csr_wb_pc,
      input  csr_ertn_flush, flush_pipe, redirect_valid, redirect_pc
`ifdef EXC_BADV_EN
      , input badv_we, badv_wdata
`endif
   );

   // slave: the commit controller
   modport slave (
      input  wb_valid, wb_pc, wb_exc, wb_ertn, wb_vaddr,
      input  has_int, ex_entry, csr_era, redirect_ready,
      output wb_ready, csr_wb_ex, csr_wb_ecode, csr_wb_esubcode, csr_wb_pc,
      output csr_ertn_flush, flush_pipe, redirect_valid, redirect_pc
`ifdef EXC_BADV_EN
      , output badv_we, badv_wdata
`endif
   );
endinterface

`default_nettype wire

// File: rtl/exc_commit_ctrl.sv
// ============================================================================
// Module  : exc_commit_ctrl
// Purpose : WB exception / ERTN commit sequencer: CSR pulses, flush, redirect.
//           Optional BADV update enabled by macro EXC_BADV_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exc_commit_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  wire               clk,
   input  wire               reset,
   exc_commit_ctrl_if.slave  bus
);

   localparam logic [5:0] c_ecode_int  = 6'h00;
   localparam logic [5:0] c_ecode_adef = 6'h08;
   localparam logic [5:0] c_ecode_ine  = 6'h0D;
   localparam logic [5:0] c_ecode_sys  = 6'h0B;
   localparam logic [5:0] c_ecode_brk  = 6'h0C;
   localparam logic [5:0] c_ecode_ale  = 6'h09;
   localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMMIT   = 2'd1,
      FLUSH    = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        int_pend_q, int_pend_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ertn_q, ertn_d;
   logic [5:0]  ecode_q, ecode_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rpc_q, rpc_d;

   logic        wb_ready;
   logic        csr_wb_ex;
   logic [5:0]  csr_wb_ecode;
   logic [31:0] csr_wb_pc;
   logic        csr_ertn_flush;
   logic        flush_pipe;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        take_exc;
   logic [5:0]  ecode_sel;

`ifdef EXC_BADV_EN
   logic        badv_en_q, badv_en_d;
   logic [31:0] badv_data_q, badv_data_d;
   logic        badv_we;
   logic [31:0] badv_wdata;
`endif

   // Interrupt outranks every synchronous exception; ADEF..ALE follow in order.
   always_comb begin
      take_exc  = int_pend_q | (|bus.wb_exc);
      ecode_sel = c_ecode_int;
      if (int_pend_q)          ecode_sel = c_ecode_int;
      else if (bus.wb_exc[0])  ecode_sel = c_ecode_adef;
      else if (bus.wb_exc[1])  ecode_sel = c_ecode_ine;
      else if (bus.wb_exc[2])  ecode_sel = c_ecode_sys;
      else if (bus.wb_exc[3])  ecode_sel = c_ecode_brk;
      else if (bus.wb_exc[4])  ecode_sel = c_ecode_ale;
   end

   always_comb begin
      state_d        = state_q;
      int_pend_d     = bus.has_int;
      cnt_d          = cnt_q;
      ertn_d         = ertn_q;
      ecode_d        = ecode_q;
      pc_d           = pc_q;
      rpc_d          = rpc_q;
      wb_ready       = 1'b0;
      csr_wb_ex      = 1'b0;
      csr_wb_ecode   = 6'd0;
      csr_wb_pc      = 32'd0;
      csr_ertn_flush = 1'b0;
      flush_pipe     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
`ifdef EXC_BADV_EN
      badv_en_d      = badv_en_q;
      badv_data_d    = badv_data_q;
      badv_we        = 1'b0;
      badv_wdata     = 32'd0;
`endif

      case (state_q)
         IDLE: begin
            wb_ready = 1'b1;
            if (bus.wb_valid && (take_exc || bus.wb_ertn)) begin
               ertn_d  = ~take_exc;
               ecode_d = ecode_sel;
               pc_d    = bus.wb_pc;
`ifdef EXC_BADV_EN
               badv_en_d   = take_exc && ((ecode_sel == c_ecode_adef) ||
                                          (ecode_sel == c_ecode_ale));
               badv_data_d = (ecode_sel == c_ecode_adef) ? bus.wb_pc : bus.wb_vaddr;
`endif
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            flush_pipe = 1'b1;
            if (ertn_q) begin
               csr_ertn_flush = 1'b1;
            end else begin
               csr_wb_ex    = 1'b1;
               csr_wb_ecode = ecode_q;
               csr_wb_pc    = pc_q;
            end
`ifdef EXC_BADV_EN
            badv_we    = badv_en_q;
            badv_wdata = badv_en_q ? badv_data_q : 32'd0;
`endif
            cnt_d   = c_flush_load;
            state_d = FLUSH;
         end
         FLUSH: begin
            flush_pipe = 1'b1;
            cnt_d      = cnt_q - 4'd1;
            // Target sampled here so the CSR update from COMMIT is visible.
            if (cnt_q <= 4'd1) begin
               rpc_d   = ertn_q ? bus.csr_era : bus.ex_entry;
               state_d = REDIRECT;
            end
         end
         REDIRECT: begin
            flush_pipe     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = rpc_q;
            if (bus.redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         int_pend_q <= 1'b0;
         cnt_q      <= 4'd0;
         ertn_q     <= 1'b0;
         ecode_q    <= 6'd0;
         pc_q       <= 32'd0;
         rpc_q      <= 32'd0;
`ifdef EXC_BADV_EN
         badv_en_q   <= 1'b0;
         badv_data_q <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         int_pend_q <= int_pend_d;
         cnt_q      <= cnt_d;
         ertn_q     <= ertn_d;
         ecode_q    <= ecode_d;
         pc_q       <= pc_d;
         rpc_q      <= rpc_d;
`ifdef EXC_BADV_EN
         badv_en_q   <= badv_en_d;
         badv_data_q <= badv_data_d;
`endif
      end
   end

   assign bus.wb_ready        = wb_ready;
   assign bus.csr_wb_ex       = csr_wb_ex;
   assign bus.csr_wb_ecode    = csr_wb_ecode;
   assign bus.csr_wb_esubcode = 9'd0;
   assign bus.csr_wb_pc       = csr_wb_pc;
   assign bus.csr_ertn_flush  = csr_ertn_flush;
   assign bus.flush_pipe      = flush_pipe;
   assign bus.redirect_valid  = redirect_valid;
   assign bus.redirect_pc     = redirect_pc;
`ifdef EXC_BADV_EN
   assign bus.badv_we         = badv_we;
   assign bus.badv_wdata      = badv_wdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
// ============================================================================
// Module  : tb_exc_commit_ctrl
// Purpose : Directed bench for exc_commit_ctrl (build with EXC_BADV_EN for BADV).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exc_commit_ctrl;

   localparam int FC = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   exc_commit_ctrl_if bus ();

   exc_commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [31:0] pc, input logic [4:0] exc, input logic ertn);
      bus.wb_valid = 1'b1;
      bus.wb_pc    = pc;
      bus.wb_exc   = exc;
      bus.wb_ertn  = ertn;
      check_vec("acc.wb_ready", 32'(bus.wb_ready), 32'd1);
      tick();
      bus.wb_valid = 1'b0;
      bus.wb_exc   = 5'd0;
      bus.wb_ertn  = 1'b0;
   endtask

   // Called in the COMMIT cycle; walks FLUSH and REDIRECT with redirect_ready=1.
   task automatic check_seq(input string nm, input logic ertn, input logic [5:0] ecode,
                            input logic [31:0] pc, input logic [31:0] target);
      check_vec({nm, ".ex"},    32'(bus.csr_wb_ex),      ertn ? 32'd0 : 32'd1);
      check_vec({nm, ".ertn"},  32'(bus.csr_ertn_flush), ertn ? 32'd1 : 32'd0);
      if (!ertn) begin
         check_vec({nm, ".ecode"}, 32'(bus.csr_wb_ecode), 32'(ecode));
         check_vec({nm, ".pc"},    bus.csr_wb_pc,         pc);
      end
      check_vec({nm, ".esub"},  32'(bus.csr_wb_esubcode), 32'd0);
      check_vec({nm, ".flushC"}, 32'(bus.flush_pipe),    32'd1);
      check_vec({nm, ".rdyC"},   32'(bus.wb_ready),      32'd0);
      for (int i = 0; i < FC; i++) begin
         tick();
         check_vec({nm, ".flushF"}, 32'(bus.flush_pipe),     32'd1);
         check_vec({nm, ".rvF"},    32'(bus.redirect_valid), 32'd0);
         check_vec({nm, ".exF"},    32'({bus.csr_wb_ex, bus.csr_ertn_flush}), 32'd0);
         check_vec({nm, ".ecodeF"}, 32'(bus.csr_wb_ecode),   32'd0);
      end
      tick();
      check_vec({nm, ".rv"},     32'(bus.redirect_valid), 32'd1);
      check_vec({nm, ".rpc"},    bus.redirect_pc,         target);
      check_vec({nm, ".flushR"}, 32'(bus.flush_pipe),     32'd1);
      tick();
      check_vec({nm, ".rvI"},    32'(bus.redirect_valid), 32'd0);
      check_vec({nm, ".flushI"}, 32'(bus.flush_pipe),     32'd0);
      check_vec({nm, ".rdyI"},   32'(bus.wb_ready),       32'd1);
   endtask

   initial begin
      logic [31:0] held_pc;
      bus.wb_valid       = 1'b0;
      bus.wb_pc          = 32'd0;
      bus.wb_exc         = 5'd0;
      bus.wb_ertn        = 1'b0;
      bus.wb_vaddr       = 32'd0;
      bus.has_int        = 1'b0;
      bus.ex_entry       = 32'h1C00_8000;
      bus.csr_era        = 32'h1C00_0100;
      bus.redirect_ready = 1'b1;

      tick();
      tick();
      check_vec("rst.wb_ready", 32'(bus.wb_ready),       32'd1);
      check_vec("rst.flush",    32'(bus.flush_pipe),     32'd0);
      check_vec("rst.rv",       32'(bus.redirect_valid), 32'd0);
      check_vec("rst.pulses",   32'({bus.csr_wb_ex, bus.csr_ertn_flush}), 32'd0);
      check_vec("rst.rpc",      bus.redirect_pc,         32'd0);
      check_vec("rst.wbpc",     bus.csr_wb_pc,           32'd0);
      reset = 1'b0;
      tick();

      // SYS exception
      accept(32'h1C00_0010, 5'b00100, 1'b0);
      check_seq("sys", 1'b0, 6'h0B, 32'h1C00_0010, 32'h1C00_8000);

      // ERTN
      accept(32'h1C00_0020, 5'b00000, 1'b1);
      check_seq("ertn", 1'b1, 6'h00, 32'h0, 32'h1C00_0100);

      // Priority: ADEF wins over INE/ALE and suppresses ERTN
      bus.wb_vaddr = 32'hDEAD_BEE0;
      accept(32'h1C00_0030, 5'b10011, 1'b1);
`ifdef EXC_BADV_EN
      check_vec("prio.badv_we",   32'(bus.badv_we), 32'd1);
      check_vec("prio.badv_data", bus.badv_wdata,   32'h1C00_0030);
`endif
      check_seq("prio", 1'b0, 6'h08, 32'h1C00_0030, 32'h1C00_8000);

      // ALE alone
      accept(32'h1C00_0040, 5'b10000, 1'b0);
`ifdef EXC_BADV_EN
      check_vec("ale.badv_data", bus.badv_wdata, 32'hDEAD_BEE0);
`endif
      check_seq("ale", 1'b0, 6'h09, 32'h1C00_0040, 32'h1C00_8000);

      // Normal retire: nothing happens
      accept(32'h1C00_0050, 5'b00000, 1'b0);
      check_vec("norm.pulses", 32'({bus.csr_wb_ex, bus.csr_ertn_flush}), 32'd0);
      check_vec("norm.flush",  32'(bus.flush_pipe), 32'd0);
      check_vec("norm.rdy",    32'(bus.wb_ready),   32'd1);

      // Interrupt pending from previous cycle
      bus.has_int = 1'b1;
      tick();
      bus.has_int = 1'b0;
      accept(32'h1C00_0200, 5'b00000, 1'b0);
      check_seq("int", 1'b0, 6'h00, 32'h1C00_0200, 32'h1C00_8000);

      // Backpressure on redirect
      bus.redirect_ready = 1'b0;
      accept(32'h1C00_0060, 5'b01000, 1'b0);
      check_vec("bp.ecode", 32'(bus.csr_wb_ecode), 32'h0C);
      for (int i = 0; i < FC + 1; i++) tick();
      held_pc      = 32'h1C00_8000;
      bus.ex_entry = 32'h1C00_9999;
      for (int i = 0; i < 5; i++) begin
         check_vec("bp.rv",    32'(bus.redirect_valid), 32'd1);
         check_vec("bp.rpc",   bus.redirect_pc,         held_pc);
         check_vec("bp.flush", 32'(bus.flush_pipe),     32'd1);
         check_vec("bp.rdy",   32'(bus.wb_ready),       32'd0);
         tick();
      end
      bus.redirect_ready = 1'b1;
      check_vec("bp.rv_last", 32'(bus.redirect_valid), 32'd1);
      tick();
      check_vec("bp.idle_rv",  32'(bus.redirect_valid), 32'd0);
      check_vec("bp.idle_rdy", 32'(bus.wb_ready),       32'd1);
      bus.ex_entry = 32'h1C00_8000;

      // Reset mid-FLUSH
      accept(32'h1C00_0070, 5'b00010, 1'b0);
      tick();
      check_vec("rf.inflush", 32'(bus.flush_pipe), 32'd1);
      reset = 1'b1;
      tick();
      check_vec("rf.flush", 32'(bus.flush_pipe),     32'd0);
      check_vec("rf.rv",    32'(bus.redirect_valid), 32'd0);
      check_vec("rf.rdy",   32'(bus.wb_ready),       32'd1);
      check_vec("rf.ex",    32'(bus.csr_wb_ex),      32'd0);
      reset = 1'b0;
      accept(32'h1C00_0080, 5'b00000, 1'b0);
      check_vec("rf.norm_pulses", 32'({bus.csr_wb_ex, bus.csr_ertn_flush}), 32'd0);
      check_vec("rf.norm_flush",  32'(bus.flush_pipe), 32'd0);
      tick();
      check_vec("rf.norm_rdy",    32'(bus.wb_ready),   32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Writeback-stage exception and ERTN commit sequencer for the CSR unit.
- Accepts one retiring instruction per cycle from WB and prioritises its exception flags against a pending interrupt.
- Drives the one-cycle exception/ERTN update pulses into the CSR unit, holds a pipeline flush, then hands the redirect target (exception entry or ERA) to Pre-IF over a valid/ready handshake.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_pipe is held in FLUSH before redirect; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB presents a retiring instruction
- wb_ready  out  1  controller accepts WB instruction this cycle
- wb_pc  in  32  PC of WB instruction
- wb_exc  in  5  flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE
- wb_ertn  in  1  WB instruction is ERTN
- wb_vaddr  in  32  faulting data address, for ALE
- has_int  in  1  interrupt request from CSR unit
- ex_entry  in  32  exception entry from CSR unit
- csr_era  in  32  ERA value from CSR unit
- csr_wb_ex  out  1  exception commit pulse to CSR unit
- csr_wb_ecode  out  6  exception code
- csr_wb_esubcode  out  9  exception subcode, always 0
- csr_wb_pc  out  32  PC to be written to ERA
- csr_ertn_flush  out  1  ERTN commit pulse to CSR unit
- flush_pipe  out  1  flush all pipeline stages
- redirect_valid  out  1  redirect request to Pre-IF
- redirect_ready  in  1  Pre-IF accepts redirect
- redirect_pc  out  32  redirect target
- badv_we  out  1  BADV write strobe; exists only with the optional feature
- badv_wdata  out  32  BADV value; exists only with the optional feature

Behaviour:
- Reset: state=IDLE, int_pend=0, flush counter=0; every output 0 except wb_ready=1.
- int_pend is a register, loaded with has_int every cycle; cleared by reset.
- wb_ready=1 only in IDLE.
- An instruction is accepted when wb_valid & wb_ready.
- Event selection at acceptance, in priority order:
  - int_pend: ecode 0x00 (INT).
  - ADEF: ecode 0x08.
  - INE: ecode 0x0D.
  - SYS: ecode 0x0B.
  - BRK: ecode 0x0C.
  - ALE: ecode 0x09.
  - Else if wb_ertn: ERTN event.
  - Else: normal retire; no state change, stay IDLE.
- An exception or interrupt suppresses a simultaneous ERTN. Multiple wb_exc bits resolve by the priority above.
- On an accepted exception or ERTN: latch ecode, wb_pc, wb_vaddr and the event type; next state is COMMIT.
- States:
  - IDLE: described above.
  - COMMIT (1 cycle):
    - Exception: csr_wb_ex=1, with csr_wb_ecode/csr_wb_pc from the latched values.
    - ERTN: csr_ertn_flush=1.
    - flush_pipe=1. Load counter with FLUSH_CYCLES. Go to FLUSH.
  - FLUSH: flush_pipe=1; counter decrements each cycle; when the counter reaches 1, go to REDIRECT.
  - REDIRECT:
    - flush_pipe=1, redirect_valid=1.
    - redirect_pc = ex_entry (exception) or csr_era (ERTN), captured on the FLUSH->REDIRECT edge. This is after the CSR update has landed.
    - redirect_pc stays stable while redirect_ready=0.
    - On redirect_valid & redirect_ready: go to IDLE; flush_pipe and redirect_valid drop the next cycle.
- Pulse and hold rules:
  - csr_wb_ex and csr_ertn_flush are never high together and never high for more than 1 cycle per event.
  - csr_wb_ecode, csr_wb_esubcode and csr_wb_pc are 0 outside COMMIT.
- Latency: acceptance at edge N; COMMIT in cycle N+1; first redirect_valid in cycle N+2+FLUSH_CYCLES.
- has_int changes during COMMIT/FLUSH/REDIRECT only update int_pend; the interrupt is taken on the next accepted instruction.
- Reset in any state returns to IDLE on that edge with all outputs at their reset values.

Optional Feature:
- Macro: EXC_BADV_EN.
- Defined:
  - badv_we=1 in COMMIT for ADEF (badv_wdata=latched wb_pc) or ALE (badv_wdata=latched wb_vaddr).
  - badv_we=0 and badv_wdata=0 otherwise.
- Undefined: badv_we/badv_wdata ports absent; wb_vaddr is ignored.

Test Plan:
- SYS: wb_valid=1, wb_exc=5'b00100, wb_pc=0x1C000010, ex_entry=0x1C008000, redirect_ready=1, FLUSH_CYCLES=2 -> csr_wb_ex pulse with ecode 0x0B and pc 0x1C000010 one cycle after acceptance; flush_pipe high 4 cycles; redirect_pc=0x1C008000 on the 4th cycle after acceptance.
- ERTN: wb_ertn=1, csr_era=0x1C000100 -> csr_ertn_flush single pulse; csr_wb_ex=0; redirect_pc=0x1C000100.
- Priority: wb_exc=5'b10011 with wb_ertn=1 -> ecode 0x08 only; no ertn pulse.
- Interrupt: has_int=1 one cycle before a normal instruction at 0x1C000200 -> ecode 0x00, csr_wb_pc=0x1C000200.
- Backpressure: redirect_ready=0 for 5 cycles in REDIRECT -> redirect_valid, redirect_pc and flush_pipe held stable; wb_ready=0 throughout; IDLE one cycle after ready=1.
- Reset mid-FLUSH -> next cycle all outputs 0, wb_ready=1; a following normal instruction produces no pulses.
